// File: rtl/sprite_draw_sched.sv
// Frame-level sprite scheduler: walks the sprite table in index order on each
// frame request and hands every enabled entry to the drawer, one job at a time.
module sprite_draw_sched #(
   parameter int NUM_SPRITES = 16,
   parameter int IDX_W       = 4,
   parameter int TIMEOUT     = 1024
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tbl_we,
   input  logic [IDX_W-1:0] tbl_addr,
   input  logic [16:0]      tbl_coord,
   input  logic [7:0]       tbl_img,
   input  logic             tbl_en,
   input  logic             frame_start,
   output logic             busy,
   output logic             frame_done,
   output logic             timeout_err,
   output logic             draw_start,
   output logic [16:0]      draw_coord,
   output logic [7:0]       draw_img,
   input  logic             draw_done
);

   localparam int CNT_W = $clog2(TIMEOUT);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPRITES - 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      SCAN,
      ISSUE,
      WAIT_CLR,
      WAIT_DONE,
      FIN
   } state_t;

   state_t state, state_nx;

   logic [IDX_W-1:0]       idx;
   logic [CNT_W-1:0]       tcnt;
   logic [16:0]            ent_coord [NUM_SPRITES];
   logic [7:0]             ent_img   [NUM_SPRITES];
   logic [NUM_SPRITES-1:0] ent_en;

   logic cur_en;
   logic at_last;
   logic job_end;

   always_comb begin
      cur_en  = ent_en[idx];
      at_last = (idx == LAST_IDX);
      job_end = draw_done || (tcnt == LAST_CNT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent_en    <= '0;
         ent_coord <= '{default: '0};
         ent_img   <= '{default: '0};
      end else if (tbl_we) begin
         ent_en[tbl_addr]    <= tbl_en;
         ent_coord[tbl_addr] <= tbl_coord;
         ent_img[tbl_addr]   <= tbl_img;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:      if (frame_start) state_nx = SCAN;
         SCAN: begin
            if (cur_en)       state_nx = ISSUE;
            else if (at_last) state_nx = FIN;
         end
         ISSUE:     state_nx = WAIT_CLR;
         WAIT_CLR:  state_nx = WAIT_DONE;
         WAIT_DONE: if (job_end) state_nx = at_last ? FIN : SCAN;
         FIN:       state_nx = IDLE;
         default:   state_nx = IDLE;
      endcase
   end

   // idx only advances past an entry once it is finished with, so it never wraps
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx         <= '0;
         tcnt        <= '0;
         timeout_err <= 1'b0;
         draw_coord  <= '0;
         draw_img    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (frame_start) begin
                  idx         <= '0;
                  timeout_err <= 1'b0;
               end
            end
            SCAN: begin
               if (cur_en) begin
                  draw_coord <= ent_coord[idx];
                  draw_img   <= ent_img[idx];
               end else if (!at_last) begin
                  idx <= idx + 1'b1;
               end
            end
            WAIT_CLR:  tcnt <= '0;
            WAIT_DONE: begin
               tcnt <= tcnt + 1'b1;
               if (job_end) begin
                  if (!draw_done) timeout_err <= 1'b1;
                  if (!at_last)   idx <= idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy       = (state != IDLE);
   assign draw_start = (state == ISSUE);
   assign frame_done = (state == FIN);

endmodule

// File: tb/tb_sprite_draw_sched.sv
// Randomised and directed bench for sprite_draw_sched, compared every cycle
// against a sequential walk model of the frame schedule.
module tb_sprite_draw_sched;

   localparam int N  = 16;
   localparam int IW = 4;
   localparam int TO = 1024;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          tbl_we = 1'b0;
   logic [IW-1:0] tbl_addr = '0;
   logic [16:0]   tbl_coord = '0;
   logic [7:0]    tbl_img = '0;
   logic          tbl_en = 1'b0;
   logic          frame_start = 1'b0;
   logic          busy, frame_done, timeout_err, draw_start;
   logic [16:0]   draw_coord;
   logic [7:0]    draw_img;
   logic          draw_done = 1'b0;

   sprite_draw_sched #(.NUM_SPRITES(N), .IDX_W(IW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
      .tbl_coord(tbl_coord), .tbl_img(tbl_img), .tbl_en(tbl_en),
      .frame_start(frame_start), .busy(busy), .frame_done(frame_done),
      .timeout_err(timeout_err), .draw_start(draw_start),
      .draw_coord(draw_coord), .draw_img(draw_img), .draw_done(draw_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int c0 = 0;
   bit chk_on = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [16:0] m_coord [N];
   logic [7:0]  m_img   [N];
   logic        m_en    [N];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            m_en[i] <= 1'b0; m_coord[i] <= '0; m_img[i] <= '0;
         end
      end else if (tbl_we) begin
         m_en[tbl_addr] <= tbl_en; m_coord[tbl_addr] <= tbl_coord; m_img[tbl_addr] <= tbl_img;
      end
   end

   logic        e_busy = 1'b0, e_start = 1'b0, e_done = 1'b0, e_terr = 1'b0;
   logic [16:0] e_coord = '0;
   logic [7:0]  e_img = '0;

   task automatic m_clear();
      e_busy = 1'b0; e_start = 1'b0; e_done = 1'b0; e_terr = 1'b0;
      e_coord = '0; e_img = '0;
   endtask

   // Each @(posedge) below closes one cycle of the frame; values set after it
   // are what the outputs must show during the following cycle.
   task automatic run_frame();
      int k;
      e_busy = 1'b1; e_terr = 1'b0;
      for (int i = 0; i < N; i++) begin
         @(posedge clk); if (!rst_n) begin m_clear(); return; end
         if (m_en[i]) begin
            e_coord = m_coord[i]; e_img = m_img[i]; e_start = 1'b1;
            @(posedge clk); if (!rst_n) begin m_clear(); return; end
            e_start = 1'b0;
            @(posedge clk); if (!rst_n) begin m_clear(); return; end
            k = 0;
            forever begin
               @(posedge clk); if (!rst_n) begin m_clear(); return; end
               if (draw_done) break;
               if (k == TO - 1) begin e_terr = 1'b1; break; end
               k++;
            end
         end
      end
      e_done = 1'b1;
      @(posedge clk); if (!rst_n) begin m_clear(); return; end
      e_done = 1'b0; e_busy = 1'b0;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         if (!rst_n) m_clear();
         else if (frame_start) run_frame();
      end
   end

   // ---------------- compare process + job log ----------------
   int          job_cyc   [$];
   logic [16:0] job_coord [$];
   logic [7:0]  job_img   [$];

   always @(negedge clk) begin
      if (chk_on) begin
         chk("busy", busy, e_busy);
         chk("draw_start", draw_start, e_start);
         chk("frame_done", frame_done, e_done);
         chk("timeout_err", timeout_err, e_terr);
         chk("draw_coord", draw_coord, e_coord);
         chk("draw_img", draw_img, e_img);
         if (draw_start) begin
            job_cyc.push_back(cyc); job_coord.push_back(draw_coord); job_img.push_back(draw_img);
         end
      end
   end

   // ---------------- drawer model ----------------
   int          d_lat = 70;
   bit          d_stale = 1'b0, d_rand = 1'b0, d_hang = 1'b0, d_job = 1'b0;
   logic [16:0] d_hang_coord = '0;
   int          d_cnt = 0, d_clr = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         draw_done = 1'b0; d_job = 1'b0;
      end else if (draw_start) begin
         d_job = 1'b1;
         d_cnt = d_rand ? int'($urandom_range(1, 12)) : d_lat;
         if (d_rand) d_stale = bit'($urandom_range(0, 1));
         if (d_stale) d_clr = 1;
         else begin d_clr = 0; draw_done = 1'b0; end
      end else if (d_job) begin
         if (d_clr > 0) begin d_clr--; if (d_clr == 0) draw_done = 1'b0; end
         if (!(d_hang && draw_coord == d_hang_coord)) begin
            d_cnt--;
            if (d_cnt <= 0) begin draw_done = 1'b1; d_job = 1'b0; end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic wr(input int a, input logic [16:0] c, input logic [7:0] im, input logic en);
      tbl_we = 1'b1; tbl_addr = IW'(a); tbl_coord = c; tbl_img = im; tbl_en = en;
      @(negedge clk);
      tbl_we = 1'b0;
   endtask

   task automatic clear_log();
      job_cyc.delete(); job_coord.delete(); job_img.delete();
   endtask

   task automatic go();
      clear_log();
      frame_start = 1'b1; c0 = cyc;
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   task automatic wait_frame(input int budget, output int off, output int bcnt);
      off = -1; bcnt = 0;
      for (int k = 0; k < budget; k++) begin
         if (busy) bcnt++;
         if (frame_done) begin off = cyc - c0; break; end
         @(negedge clk);
      end
      if (off < 0) begin
         checks++; errors++;
         $display("FAIL frame_wait: no frame_done within %0d cycles", budget);
      end else @(negedge clk);
   endtask

   task automatic wait_start(input int budget);
      bit seen = 1'b0;
      for (int k = 0; k < budget; k++) begin
         if (draw_start) begin seen = 1'b1; break; end
         @(negedge clk);
      end
      if (!seen) begin
         checks++; errors++;
         $display("FAIL start_wait: no draw_start within %0d cycles", budget);
      end
   endtask

   initial begin
      int off, bc;
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int off, bc;
      repeat (3) @(negedge clk);
      chk_on = 1'b1;
      chk("rst_busy", busy, 0); chk("rst_start", draw_start, 0); chk("rst_done", frame_done, 0);
      chk("rst_terr", timeout_err, 0); chk("rst_coord", draw_coord, 0); chk("rst_img", draw_img, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // empty table
      go(); wait_frame(100, off, bc);
      chk("empty_done_cycle", off, 17); chk("empty_busy_cycles", bc, 17);
      chk("empty_starts", job_cyc.size(), 0);

      // two entries, 70-cycle drawer
      wr(0, 17'h00A0A, 8'h03, 1'b1); wr(5, 17'h1F000, 8'h7E, 1'b1);
      d_lat = 70; go(); wait_frame(400, off, bc);
      chk("two_done_cycle", off, 159); chk("two_jobs", job_cyc.size(), 2);
      chk("two_terr", timeout_err, 0);
      if (job_cyc.size() == 2) begin
         chk("j0_cycle", job_cyc[0] - c0, 2); chk("j1_cycle", job_cyc[1] - c0, 78);
         chk("j0_coord", job_coord[0], 17'h00A0A); chk("j0_img", job_img[0], 8'h03);
         chk("j1_coord", job_coord[1], 17'h1F000); chk("j1_img", job_img[1], 8'h7E);
      end

      // stale draw_done level carried into each job
      wr(6, 17'h00123, 8'h44, 1'b1);
      d_stale = 1'b1; d_lat = 5; go(); wait_frame(400, off, bc);
      chk("stale_done_cycle", off, 35); chk("stale_jobs", job_cyc.size(), 3);
      if (job_cyc.size() == 3) begin
         chk("stale_j1_cycle", job_cyc[1] - c0, 13); chk("stale_j2_coord", job_coord[2], 17'h00123);
      end
      d_stale = 1'b0;

      // drawer hangs on entry 2
      wr(0, 17'h0, 8'h0, 1'b0); wr(5, 17'h0, 8'h0, 1'b0); wr(6, 17'h0, 8'h0, 1'b0);
      wr(1, 17'h00111, 8'h11, 1'b1); wr(2, 17'h00222, 8'h22, 1'b1); wr(3, 17'h00333, 8'h33, 1'b1);
      d_lat = 4; d_hang = 1'b1; d_hang_coord = 17'h00222;
      go(); wait_frame(3000, off, bc);
      chk("to_terr", timeout_err, 1); chk("to_jobs", job_cyc.size(), 3);
      if (job_cyc.size() == 3) chk("to_gap", job_cyc[2] - job_cyc[1], 1027);
      d_hang = 1'b0;
      go(); chk("to_terr_cleared", timeout_err, 0);
      wait_frame(400, off, bc); chk("to_terr_after", timeout_err, 0);

      // in-flight write, ignored frame_start, write ahead of the walk
      wr(1, 17'h0, 8'h0, 1'b0); wr(2, 17'h0, 8'h0, 1'b0); wr(9, 17'h09090, 8'h99, 1'b1);
      d_lat = 30; go(); wait_start(100);
      repeat (5) @(negedge clk);
      wr(3, 17'h1ABCD, 8'hEE, 1'b1);
      frame_start = 1'b1; @(negedge clk); frame_start = 1'b0;
      wr(9, 17'h05555, 8'h55, 1'b1);
      wait_frame(400, off, bc);
      chk("fly_jobs", job_cyc.size(), 2);
      if (job_cyc.size() == 2) begin
         chk("fly_j0_coord", job_coord[0], 17'h00333); chk("fly_j0_img", job_img[0], 8'h33);
         chk("fly_j1_coord", job_coord[1], 17'h05555); chk("fly_j1_img", job_img[1], 8'h55);
      end
      repeat (5) @(negedge clk);
      chk("fly_no_refire", busy, 0);

      // randomised traffic
      d_rand = 1'b1;
      for (int k = 0; k < 4000; k++) begin
         tbl_we      = ($urandom_range(0, 7) == 0);
         tbl_addr    = IW'($urandom_range(0, N - 1));
         tbl_coord   = 17'($urandom);
         tbl_img     = 8'($urandom);
         tbl_en      = 1'($urandom_range(0, 1));
         frame_start = ($urandom_range(0, 29) == 0);
         @(negedge clk);
      end
      tbl_we = 1'b0; frame_start = 1'b0;
      for (int k = 0; k < 2000 && busy; k++) @(negedge clk);
      chk("rand_drained", busy, 0);
      d_rand = 1'b0; d_stale = 1'b0;

      // reset during WAIT_DONE
      wr(4, 17'h04444, 8'h44, 1'b1);
      d_lat = 50; go(); wait_start(100);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0); chk("mid_rst_start", draw_start, 0);
      chk("mid_rst_done", frame_done, 0); chk("mid_rst_terr", timeout_err, 0);
      chk("mid_rst_coord", draw_coord, 0); chk("mid_rst_img", draw_img, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      go(); wait_frame(100, off, bc);
      chk("post_rst_done_cycle", off, 17); chk("post_rst_starts", job_cyc.size(), 0);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sprite_draw_sched.md
Name:
sprite_draw_sched

Overview:
- Frame-level scheduler for the sprite drawer.
- Holds a table of sprite entries (coordinates, image select, enable) written by move logic.
- On a frame trigger, walks the table in index order and issues one draw job per enabled entry: pulses the drawer's start, waits for its done level, advances.
- Sits between move logic and the sprite drawer. Signals frame completion to the display/frame-swap logic.

Parameters:
- NUM_SPRITES, 16, number of table entries; must be a power of 2, from 2 to 256.
- IDX_W, 4, log2(NUM_SPRITES).
- TIMEOUT, 1024, cycles the block waits for draw_done before abandoning an entry; must be ≥ 4.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- tbl_we  in  1  table write strobe
- tbl_addr  in  IDX_W  entry index for write
- tbl_coord  in  17  sprite frame coordinates for write
- tbl_img  in  8  sprite image select for write
- tbl_en  in  1  entry enable for write
- frame_start  in  1  single-cycle request to draw all enabled sprites
- busy  out  1  high from frame_start acceptance until frame_done
- frame_done  out  1  one-cycle pulse when the table walk completes
- timeout_err  out  1  sticky; set if any entry timed out this frame
- draw_start  out  1  one-cycle start pulse to the drawer
- draw_coord  out  17  coordinates to the drawer, registered
- draw_img  out  8  image select to the drawer, registered
- draw_done  in  1  drawer done level; set at job end, cleared the cycle after draw_start

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, idx=0, timeout counter=0.
  - All table enables=0, table coord/img=0.
  - busy=0, frame_done=0, timeout_err=0, draw_start=0, draw_coord=0, draw_img=0.
  - Reset mid-frame aborts the walk immediately; no frame_done is produced.
- Table writes:
  - On tbl_we, entry[tbl_addr] <= {tbl_coord, tbl_img, tbl_en} at the clock edge. Accepted in any state.
  - draw_coord/draw_img are captured at SCAN, so a write to the entry currently in flight does not affect the issued job.
  - A write to an entry the walk has not yet reached takes effect this frame.
  - A write to the entry being scanned in the same cycle: the scan sees the old value.
- States: IDLE, SCAN, ISSUE, WAIT_CLR, WAIT_DONE, FIN.
  - IDLE: frame_start=1 → idx<=0, timeout_err<=0, go SCAN. frame_start in any other state is ignored; no queuing.
  - SCAN, entry[idx].en=1: draw_coord<=entry.coord, draw_img<=entry.img, go ISSUE.
  - SCAN, entry disabled and idx==NUM_SPRITES-1: go FIN.
  - SCAN, entry disabled otherwise: idx<=idx+1, stay in SCAN. Each disabled entry costs 1 cycle.
  - ISSUE: draw_start=1 for exactly this cycle; go WAIT_CLR.
  - WAIT_CLR: draw_done is ignored (it is stale from the previous job); clear the timeout counter; go WAIT_DONE.
  - WAIT_DONE: timeout counter increments each cycle.
    - draw_done=1 → advance.
    - Otherwise, counter==TIMEOUT-1 → set timeout_err, then advance.
    - draw_done and timeout in the same cycle: done wins; timeout_err is not set.
  - Advance: if idx==NUM_SPRITES-1 go FIN, else idx<=idx+1 and go SCAN.
  - FIN: frame_done=1 for one cycle; go IDLE.
- busy=1 in every state except IDLE.
- idx never wraps within a frame; it is reset only on frame acceptance.
- Timing, frame_start sampled at edge t:
  - SCAN(idx0) in cycle t+1.
  - If entry 0 is enabled, draw_start is high in cycle t+2.
  - All entries disabled: frame_done is high in cycle t+1+NUM_SPRITES.
- Per enabled entry overhead beyond the drawer's own latency: 3 cycles (SCAN, ISSUE, WAIT_CLR).
- draw_start, busy and frame_done are decoded from registered state; glitch-free.

Test Plan:
- Reset with the table empty, then pulse frame_start → busy high for 17 cycles, frame_done pulse in cycle t+17, draw_start never asserted.
- Enable entries 0 and 5 (coord 0x00A0A / img 0x03, coord 0x1F000 / img 0x7E). Drawer model asserts done 70 cycles after start → exactly two draw_start pulses carrying those values in order, then a single frame_done; timeout_err=0.
- Drawer model holds draw_done high from the previous job → the stale level is ignored in WAIT_CLR, and the next entry is not skipped.
- Drawer model never asserts done for entry 2 (TIMEOUT=1024) → walk advances 1024 cycles after WAIT_DONE entry, timeout_err=1 at frame_done. A subsequent frame_start clears it.
- frame_start pulsed again while busy, plus a tbl_we to in-flight entry 3 during WAIT_DONE → no second frame; the issued draw_coord is unchanged. A write to entry 9 mid-walk is drawn with the new value.
- rst_n asserted during WAIT_DONE → all outputs 0 immediately, table enables cleared. The next frame_start behaves like the empty-table case.
